// File: rtl/mips_cpu_halt_monitor.sv
// Supervises a MIPS core from its reset-vector fetch to the halt fetch. It then grades
// $v0 against a golden value and raises timeout or drain-stuck errors when needed.
module mips_cpu_halt_monitor #(
    parameter logic [31:0] RESET_VECTOR   = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR      = 32'h00000000,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned DRAIN_MAX      = 4,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             active,
    input  logic [31:0]      instr_address,
    input  logic [31:0]      register_v0,
    input  logic [31:0]      expected_v0,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] fetch_count,
    output logic [31:0]      captured_v0
);

    localparam int unsigned      DRAIN_W      = (DRAIN_MAX < 2) ? 1 : $clog2(DRAIN_MAX + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_MAX - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_CHECK   = 3'd3,
        ST_PASS    = 3'd4,
        ST_FAIL    = 3'd5,
        ST_TIMEOUT = 3'd6
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [DRAIN_W-1:0]   drain_cnt_r;
    logic [DRAIN_W-1:0]   drain_cnt_s;
    logic [31:0]          prev_addr_r;
    logic [31:0]          prev_addr_s;
    logic [CNT_W-1:0]     cycle_s;
    logic [CNT_W-1:0]     fetch_s;
    logic [31:0]          capt_s;
    logic [1:0]           err_s;
    logic                 done_s;
    logic                 pass_s;
    logic                 fail_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    // Next-state and next-datapath decode; the timeout exit freezes cycle_count at TIMEOUT_CYCLES-1.
    always_comb begin
        state_s     = state_r;
        drain_cnt_s = drain_cnt_r;
        prev_addr_s = prev_addr_r;
        cycle_s     = cycle_count;
        fetch_s     = fetch_count;
        capt_s      = captured_v0;
        err_s       = err_code;
        case (state_r)
            ST_IDLE: begin
                prev_addr_s = instr_address;
                if (active && (instr_address == RESET_VECTOR)) begin
                    state_s = ST_RUN;
                    cycle_s = '0;
                    fetch_s = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                prev_addr_s = instr_address;
                // cycle_count is still zero only on the first RUN cycle, which never counts a fetch
                if ((cycle_count != '0) && (instr_address != prev_addr_r)) begin
                    fetch_s = sat_inc(fetch_count);
                end else begin
                    fetch_s = fetch_count;
                end
                if (instr_address == HALT_ADDR) begin
                    state_s     = ST_DRAIN;
                    drain_cnt_s = '0;
                    cycle_s     = sat_inc(cycle_count);
                end else if (cycle_count == TIMEOUT_LAST) begin
                    state_s = ST_TIMEOUT;
                    err_s   = 2'd2;
                end else begin
                    cycle_s = sat_inc(cycle_count);
                end
            end
            ST_DRAIN: begin
                cycle_s     = sat_inc(cycle_count);
                drain_cnt_s = drain_cnt_r + DRAIN_W'(1);
                if (!active) begin
                    state_s = ST_CHECK;
                end else if (drain_cnt_r == DRAIN_LAST) begin
                    state_s = ST_FAIL;
                    err_s   = 2'd3;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_CHECK: begin
                capt_s = register_v0;
                if (register_v0 == expected_v0) begin
                    state_s = ST_PASS;
                end else begin
                    state_s = ST_FAIL;
                    err_s   = 2'd1;
                end
            end
            ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                state_s = state_r;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        pass_s = (state_s == ST_PASS);
        fail_s = (state_s == ST_FAIL) || (state_s == ST_TIMEOUT);
        done_s = pass_s || fail_s;
    end

    // State register; done/pass/fail are registered from the next state so they track it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            done    <= 1'b0;
            pass    <= 1'b0;
            fail    <= 1'b0;
        end else if (clk_enable) begin
            state_r <= state_s;
            done    <= done_s;
            pass    <= pass_s;
            fail    <= fail_s;
        end
    end

    // Counters, address history, captured value and error code.
    always_ff @(posedge clk) begin
        if (!reset) begin
            drain_cnt_r <= '0;
            prev_addr_r <= 32'h0000_0000;
            cycle_count <= '0;
            fetch_count <= '0;
            captured_v0 <= 32'h0000_0000;
            err_code    <= 2'd0;
        end else if (clk_enable) begin
            drain_cnt_r <= drain_cnt_s;
            prev_addr_r <= prev_addr_s;
            cycle_count <= cycle_s;
            fetch_count <= fetch_s;
            captured_v0 <= capt_s;
            err_code    <= err_s;
        end
    end

endmodule

// File: tb/tb_mips_cpu_halt_monitor.sv
// Randomized bench for mips_cpu_halt_monitor: each run is a pre-built trace of enabled cycles,
// graded by a trace-scanning reference model, replayed with random disabled cycles inserted.
module tb_mips_cpu_halt_monitor;

    localparam logic [31:0] RV    = 32'hBFC00000;
    localparam logic [31:0] HALT  = 32'h00000000;
    localparam int          T_CYC = 20;
    localparam int          D_MAX = 4;
    localparam int          CW    = 16;
    localparam int          N     = 48;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_enable;
    logic          active;
    logic [31:0]   instr_address;
    logic [31:0]   register_v0;
    logic [31:0]   expected_v0;
    logic          done;
    logic          pass;
    logic          fail;
    logic [1:0]    err_code;
    logic [CW-1:0] cycle_count;
    logic [CW-1:0] fetch_count;
    logic [31:0]   captured_v0;

    mips_cpu_halt_monitor #(
        .RESET_VECTOR  (RV),
        .HALT_ADDR     (HALT),
        .TIMEOUT_CYCLES(T_CYC),
        .DRAIN_MAX     (D_MAX),
        .CNT_W         (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clk_enable   (clk_enable),
        .active       (active),
        .instr_address(instr_address),
        .register_v0  (register_v0),
        .expected_v0  (expected_v0),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .err_code     (err_code),
        .cycle_count  (cycle_count),
        .fetch_count  (fetch_count),
        .captured_v0  (captured_v0)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Trace of enabled cycles, one entry per enabled clock edge.
    logic        act_a  [N];
    logic [31:0] addr_a [N];
    logic [31:0] v0_a   [N];
    logic [31:0] exp_a  [N];

    int          e_idx;
    int          e_cyc;
    int          e_fetch;
    logic        e_pass;
    logic        e_fail;
    logic [1:0]  e_err;
    logic [31:0] e_capt;
    int          first_done;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // p idle cycles, start fetch at p, halt fetch hr cycles after the first RUN cycle,
    // active held for dd drain cycles, and $v0 matching or off by one bit at the check.
    task automatic gen(input int p, input int hr, input int dd, input bit match);
        int h;
        int c;
        for (int i = 0; i < N; i++) begin
            act_a[i]  = 1'b1;
            addr_a[i] = RV + 32'(4 * $urandom_range(0, 2));
            v0_a[i]   = $urandom;
            exp_a[i]  = $urandom;
        end
        for (int i = 0; i < p; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                act_a[i]  = 1'b0;
                addr_a[i] = RV;
            end else begin
                act_a[i]  = 1'b1;
                addr_a[i] = RV + 32'd4;
            end
        end
        act_a[p]  = 1'b1;
        addr_a[p] = RV;
        h = p + 1 + hr;
        if (h < N) addr_a[h] = HALT;
        for (int i = h + 1; i < N; i++) act_a[i] = (i < h + 1 + dd);
        c = h + 2 + dd;
        if (c < N) begin
            if (match) exp_a[c] = v0_a[c];
            else       exp_a[c] = v0_a[c] ^ (32'd1 << $urandom_range(0, 31));
        end
    endtask

    // Reference model: scans the trace with the monitor's rules to predict the verdict.
    task automatic model();
        int k;
        int t;
        int ds;
        k = 0;
        while (k < N - 1 && !(act_a[k] && addr_a[k] == RV)) k++;
        k++;
        e_fetch = 0; e_cyc = 0; e_err = 2'd0; e_capt = 32'd0;
        e_pass = 1'b0; e_fail = 1'b0; e_idx = -1; ds = -1;
        for (int r = 0; r < T_CYC; r++) begin
            t = k + r;
            if (r > 0 && addr_a[t] != addr_a[t-1]) e_fetch++;
            if (addr_a[t] == HALT) begin
                e_cyc = r + 1;
                ds = t + 1;
                break;
            end
            if (r == T_CYC - 1) begin
                e_cyc = r; e_err = 2'd2; e_fail = 1'b1; e_idx = t;
            end
        end
        if (ds >= 0) begin
            for (int d = 0; d < D_MAX; d++) begin
                t = ds + d;
                if (!act_a[t]) begin
                    e_cyc += d + 1;
                    e_idx  = t + 1;
                    e_capt = v0_a[t+1];
                    if (v0_a[t+1] == exp_a[t+1]) e_pass = 1'b1;
                    else begin e_fail = 1'b1; e_err = 2'd1; end
                    break;
                end
                if (d == D_MAX - 1) begin
                    e_cyc += d + 1; e_err = 2'd3; e_fail = 1'b1; e_idx = t;
                end
            end
        end
    endtask

    task automatic idle_cycle();
        clk_enable = 1'b0;
        active     = 1'($urandom);
        case ($urandom_range(0, 2))
            0:       instr_address = RV;
            1:       instr_address = HALT;
            default: instr_address = $urandom;
        endcase
        register_v0 = $urandom;
        expected_v0 = $urandom;
        @(posedge clk); #1;
    endtask

    task automatic apply_entries(input int from, input int to, input int pct);
        if (from == 0) first_done = -1;
        for (int i = from; i < to; i++) begin
            if (int'($urandom_range(0, 99)) < pct) repeat ($urandom_range(1, 3)) idle_cycle();
            clk_enable    = 1'b1;
            active        = act_a[i];
            instr_address = addr_a[i];
            register_v0   = v0_a[i];
            expected_v0   = exp_a[i];
            @(posedge clk); #1;
            if (done === 1'b1 && first_done < 0) first_done = i;
        end
    endtask

    task automatic do_reset(input logic en);
        reset         = 1'b0;
        clk_enable    = en;
        active        = 1'b1;
        instr_address = RV;
        register_v0   = $urandom;
        expected_v0   = $urandom;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check_value({tag, "_done"},  32'(done), 32'd0);
        check_value({tag, "_pass"},  32'(pass), 32'd0);
        check_value({tag, "_fail"},  32'(fail), 32'd0);
        check_value({tag, "_err"},   32'(err_code), 32'd0);
        check_value({tag, "_cycle"}, 32'(cycle_count), 32'd0);
        check_value({tag, "_fetch"}, 32'(fetch_count), 32'd0);
        check_value({tag, "_capt"},  captured_v0, 32'd0);
    endtask

    task automatic check_result(input string tag);
        check_value({tag, "_done_at"}, 32'(first_done), 32'(e_idx));
        check_value({tag, "_done"},    32'(done), 32'd1);
        check_value({tag, "_pass"},    32'(pass), 32'(e_pass));
        check_value({tag, "_fail"},    32'(fail), 32'(e_fail));
        check_value({tag, "_err"},     32'(err_code), 32'(e_err));
        check_value({tag, "_cycle"},   32'(cycle_count), 32'(e_cyc));
        check_value({tag, "_fetch"},   32'(fetch_count), 32'(e_fetch));
        check_value({tag, "_capt"},    captured_v0, e_capt);
    endtask

    // Basic program: RV, RV, RV+4, HALT, active drops one cycle after halt.
    task automatic gen_basic(input int dd, input logic [31:0] v0, input logic [31:0] ev);
        gen(0, 2, dd, 1'b1);
        addr_a[1] = RV;
        addr_a[2] = RV + 32'd4;
        v0_a[5]   = v0;
        exp_a[5]  = ev;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset(1'b1);
        do_reset(1'b0);
        check_reset_state("reset");

        do_reset(1'b1);
        gen_basic(0, 32'd0, 32'd0);
        model();
        apply_entries(0, N, 0);
        check_result("basic_pass");
        check_value("basic_pass_fetch2", 32'(fetch_count), 32'd2);

        do_reset(1'b1);
        gen_basic(0, 32'h5, 32'h4);
        model();
        apply_entries(0, N, 0);
        check_result("v0_mismatch");
        check_value("v0_mismatch_err1", 32'(err_code), 32'd1);
        check_value("v0_mismatch_capt", captured_v0, 32'h5);

        do_reset(1'b1);
        gen(0, 100, 0, 1'b1);
        for (int i = 0; i < N; i++) addr_a[i] = (i % 2 == 0) ? RV : RV + 32'd4;
        model();
        apply_entries(0, N, 0);
        check_result("timeout");
        check_value("timeout_cycle19", 32'(cycle_count), 32'd19);

        do_reset(1'b1);
        gen_basic(10, 32'd0, 32'd0);
        model();
        apply_entries(0, N, 0);
        check_result("drain_stuck");
        check_value("drain_stuck_err3", 32'(err_code), 32'd3);

        do_reset(1'b1);
        gen(0, 19, 0, 1'b1);
        model();
        apply_entries(0, N, 0);
        check_result("halt_at_timeout");

        do_reset(1'b1);
        gen_basic(0, 32'd0, 32'd0);
        model();
        apply_entries(0, 3, 0);
        check_value("hold_before", 32'(cycle_count), 32'd2);
        repeat (10) idle_cycle();
        check_value("hold_after", 32'(cycle_count), 32'd2);
        check_value("hold_fetch", 32'(fetch_count), 32'd1);
        apply_entries(3, N, 0);
        check_result("hold_run");

        do_reset(1'b1);
        gen_basic(10, 32'd0, 32'd0);
        apply_entries(0, 5, 0);
        do_reset(1'b0);
        check_reset_state("reset_in_drain");
        gen_basic(0, 32'd0, 32'd0);
        model();
        apply_entries(0, N, 0);
        check_result("rerun");

        for (int s = 0; s < 40; s++) begin
            int hr;
            do_reset(1'($urandom));
            hr = (s % 8 == 0) ? 19 : int'($urandom_range(0, 24));
            gen(int'($urandom_range(0, 3)), hr, int'($urandom_range(0, 5)), 1'($urandom));
            model();
            apply_entries(0, N, 25);
            check_result("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mips_cpu_halt_monitor.md
MIPS_CPU_HALT_MONITOR -- requirements
Module: mips_cpu_halt_monitor

Interface
REQ-001 Parameter RESET_VECTOR, default 32'hBFC00000, fetch address that marks program start.
REQ-002 Parameter HALT_ADDR, default 32'h00000000, fetch address that marks program halt.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000, maximum enabled cycles allowed in RUN.
REQ-004 Parameter DRAIN_MAX, default 4, maximum enabled cycles waited for active to drop after halt.
REQ-005 Parameter CNT_W, default 16, width of the cycle and fetch counters.
REQ-006 clk  input  1  system clock, all state updates on posedge.
REQ-007 reset  input  1  one clock; reset is synchronous and active-low.
REQ-008 clk_enable  input  1  global enable; when 0 no register in the block changes (reset excepted).
REQ-009 active  input  1  CPU active flag.
REQ-010 instr_address  input  32  CPU instruction fetch address.
REQ-011 register_v0  input  32  CPU $v0 debug value.
REQ-012 expected_v0  input  32  golden $v0 value, sampled in CHECK.
REQ-013 done  output  1  high in PASS, FAIL or TIMEOUT.
REQ-014 pass  output  1  high only in PASS.
REQ-015 fail  output  1  high in FAIL or TIMEOUT.
REQ-016 err_code  output  2  0 none, 1 v0 mismatch, 2 timeout, 3 active stuck after halt.
REQ-017 cycle_count  output  CNT_W  enabled cycles spent in RUN and DRAIN.
REQ-018 fetch_count  output  CNT_W  number of instr_address changes seen in RUN.
REQ-019 captured_v0  output  32  register_v0 sampled in CHECK.

Function
REQ-020 States: IDLE, RUN, DRAIN, CHECK, PASS, FAIL, TIMEOUT; all transitions on posedge with clk_enable=1 only.
REQ-021 IDLE -> RUN when active=1 and instr_address==RESET_VECTOR; cycle_count and fetch_count cleared on entry.
REQ-022 RUN: cycle_count +1 per enabled cycle, saturating at all-ones.
REQ-023 RUN: fetch_count +1 when instr_address differs from its value registered on the previous enabled cycle, saturating; first RUN cycle never counts.
REQ-024 RUN -> DRAIN when instr_address==HALT_ADDR.
REQ-025 RUN -> TIMEOUT, err_code=2, when cycle_count==TIMEOUT_CYCLES-1 and halt address not present.
REQ-026 Halt address and timeout condition in the same cycle: DRAIN wins.
REQ-027 DRAIN: cycle_count keeps incrementing; internal drain counter cleared on entry, +1 per enabled cycle.
REQ-028 DRAIN -> CHECK when active=0; DRAIN -> FAIL, err_code=3, when drain counter reaches DRAIN_MAX with active still 1.
REQ-029 CHECK lasts exactly one enabled cycle: captured_v0 <= register_v0; -> PASS if register_v0==expected_v0, else -> FAIL with err_code=1.
REQ-030 PASS, FAIL, TIMEOUT are sticky until reset; counters and captured_v0 frozen there.
REQ-031 done/pass/fail are registered decodes of state: asserted on the cycle after the terminal transition.
REQ-032 Full 32-bit equality compare; no masking.
REQ-033 clk_enable=0 mid-RUN or mid-DRAIN: state, counters and drain counter hold; behaviour resumes unchanged.

Reset
REQ-034 reset=0 at a posedge forces IDLE regardless of clk_enable.
REQ-035 Reset values: done=0, pass=0, fail=0, err_code=0, cycle_count=0, fetch_count=0, captured_v0=0, drain counter=0, previous-address register=0.
REQ-036 Reset asserted in any state, including terminal states, aborts the run; a new run needs a fresh RESET_VECTOR fetch.

Verification
REQ-037 Fetch 0xBFC00000, 0xBFC00004, then 0x0; active drops 1 cycle later; v0=0, expected=0 -> pass=1, err_code=0, fetch_count=2.
REQ-038 Same sequence, v0=32'h5, expected=32'h4 -> fail=1, err_code=1, captured_v0=32'h5.
REQ-039 TIMEOUT_CYCLES=20, address loops 0xBFC00000/0xBFC00004 forever -> fail=1, err_code=2, cycle_count=19.
REQ-040 Halt reached, active held 1 -> fail=1, err_code=3 after DRAIN_MAX=4 enabled cycles in DRAIN.
REQ-041 clk_enable=0 for 10 cycles mid-RUN -> cycle_count unchanged over those cycles; final result identical to REQ-037.
REQ-042 reset=0 while in DRAIN -> next cycle IDLE, all outputs at reset values; rerun of REQ-037 passes.
